// File: rtl/tmds_clk_pkg.sv
// Shared types and width helpers for the TMDS PLL reset/lock sequencer.
package tmds_clk_pkg;

    localparam int unsigned StateW  = 3;
    localparam int unsigned RelockW = 8;

    typedef enum logic [StateW-1:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StRelease  = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } seq_state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tmds_clk_rst_seq_if.sv
// PLL-side and downstream-side signals of the reset sequencer.
interface tmds_clk_rst_seq_if #(
    parameter int unsigned N_DOMAINS = 2
) ();
    import tmds_clk_pkg::*;

    logic                 pll_lock;
    logic                 retry_req;
    logic                 pll_reset;
    logic [N_DOMAINS-1:0] dom_rst_n;
    logic                 ready;
    logic                 fault;
    logic [RelockW-1:0]   relock_count;
    logic [StateW-1:0]    state_dbg;

    modport master (
        input  pll_lock, retry_req,
        output pll_reset, dom_rst_n, ready, fault, relock_count, state_dbg
    );

    modport slave (
        output pll_lock, retry_req,
        input  pll_reset, dom_rst_n, ready, fault, relock_count, state_dbg
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow or quasi-static asynchronous inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tmds_clk_rst_seq.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies lock, then releases
// downstream domain resets in order, with timeout retries and a latched fault.
module tmds_clk_rst_seq
    import tmds_clk_pkg::*;
#(
    parameter int unsigned N_DOMAINS           = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned DOMAIN_GAP_CYCLES   = 8,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    tmds_clk_rst_seq_if.master  bus_io
);

    localparam int unsigned RelCycles = N_DOMAINS * DOMAIN_GAP_CYCLES;
    localparam int unsigned CntW   = cnt_w((PLL_RST_CYCLES > RelCycles) ? PLL_RST_CYCLES : RelCycles);
    localparam int unsigned StabW  = cnt_w(LOCK_STABLE_CYCLES);
    localparam int unsigned TmoW   = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned RetryW = cnt_w(MAX_RETRIES);

    localparam logic [CntW-1:0]   RstLast  = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0]   RelLast  = CntW'(RelCycles - 1);
    localparam logic [StabW-1:0]  StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    seq_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [StabW-1:0]     stab_q, stab_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic [RetryW-1:0]    retry_q, retry_d;
    logic [RelockW-1:0]   relock_q, relock_d;
    logic                 pll_reset_q, pll_reset_d;
    logic [N_DOMAINS-1:0] dom_q, dom_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic                 lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (resetn_i),
        .d_i    (bus_io.pll_lock),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stab_d   = stab_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                    stab_d  = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitLock: begin
                stab_d = lock_s ? stab_q + StabW'(1) : '0;
                tmo_d  = tmo_q + TmoW'(1);
                // Stability is checked first so it wins a same-cycle timeout.
                if (lock_s && (stab_q == StabLast)) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else if (tmo_q == TmoLast) begin
                    cnt_d = '0;
                    if (retry_q < RetryMax) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StPllRst;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StRelease: begin
                if (!lock_s) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end else if (cnt_q == RelLast) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (!lock_s) begin
                    state_d  = StPllRst;
                    cnt_d    = '0;
                    retry_d  = '0;
                    relock_d = (relock_q == '1) ? relock_q : relock_q + RelockW'(1);
                end
            end
            StFault: begin
                if (bus_io.retry_req) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        pll_reset_d = (state_d == StPllRst) || (state_d == StFault);
        fault_d     = (state_d == StFault);
        ready_d     = (state_d == StRun);
        dom_d       = '0;
        for (int unsigned i = 0; i < N_DOMAINS; i++) begin
            dom_d[i] = (state_d == StRun) ||
                       ((state_d == StRelease) && (32'(cnt_d) >= i * DOMAIN_GAP_CYCLES));
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            dom_q       <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            dom_q       <= dom_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign bus_io.pll_reset    = pll_reset_q;
    assign bus_io.dom_rst_n    = dom_q;
    assign bus_io.ready        = ready_q;
    assign bus_io.fault        = fault_q;
    assign bus_io.relock_count = relock_q;
    assign bus_io.state_dbg    = state_q;

endmodule

// File: tb/tb_tmds_clk_rst_seq.sv
// Scoreboard bench: stimulus queues cycle-stamped output snapshots, a monitor compares them.
module tb_tmds_clk_rst_seq;

    typedef struct packed {
        logic [2:0] st;
        logic       pr;
        logic [2:0] dom;
        logic       rdy;
        logic       flt;
        logic [7:0] rc;
    } snap_t;

    logic        clk;
    logic        resetn;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp_rc = 0;

    int unsigned q_cyc[$];
    snap_t       q_exp[$];
    string       q_tag[$];

    tmds_clk_rst_seq_if #(.N_DOMAINS(3)) seq_if ();

    tmds_clk_rst_seq #(
        .N_DOMAINS           (3),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .DOMAIN_GAP_CYCLES   (2),
        .MAX_RETRIES         (1)
    ) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus_io   (seq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs k cycles after entering PLLRST; d = extra WAIT_LOCK cycles.
    function automatic snap_t bring_snap(input int k, input int d, input int rc);
        snap_t s;
        int    t;
        s    = '0;
        s.rc = 8'(rc);
        t    = 12 + d;
        if (k < 4) begin
            s.st = 3'd0;
            s.pr = 1'b1;
        end else if (k < t) begin
            s.st = 3'd1;
        end else if (k < t + 6) begin
            s.st = 3'd2;
            if (k - t < 2)      s.dom = 3'b001;
            else if (k - t < 4) s.dom = 3'b011;
            else                s.dom = 3'b111;
        end else begin
            s.st  = 3'd3;
            s.dom = 3'b111;
            s.rdy = 1'b1;
        end
        return s;
    endfunction

    task automatic push(input int unsigned c, input snap_t s, input string t);
        q_cyc.push_back(c);
        q_exp.push_back(s);
        q_tag.push_back(t);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        snap_t act;
        act.st  = seq_if.state_dbg;
        act.pr  = seq_if.pll_reset;
        act.dom = seq_if.dom_rst_n;
        act.rdy = seq_if.ready;
        act.flt = seq_if.fault;
        act.rc  = seq_if.relock_count;
        while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
            checks++;
            if (q_cyc[0] < cyc) begin
                failures++;
                $display("FAIL %s missed cyc=%0d now=%0d", q_tag[0], q_cyc[0], cyc);
            end else if (act !== q_exp[0]) begin
                failures++;
                $display("FAIL %s cyc=%0d got st=%0d pr=%b dom=%b rdy=%b flt=%b rc=%0d want st=%0d pr=%b dom=%b rdy=%b flt=%b rc=%0d",
                         q_tag[0], cyc, act.st, act.pr, act.dom, act.rdy, act.flt, act.rc,
                         q_exp[0].st, q_exp[0].pr, q_exp[0].dom, q_exp[0].rdy, q_exp[0].flt,
                         q_exp[0].rc);
            end
            void'(q_cyc.pop_front());
            void'(q_exp.pop_front());
            void'(q_tag.pop_front());
        end
    end

    // Reset, then bring-up; filt applies the 5-on/1-off/steady lock pattern.
    task automatic reset_bringup(input bit filt);
        int unsigned c, r;
        int          d;
        d = filt ? 6 : 0;
        c = cyc;
        seq_if.retry_req = 1'b0;
        seq_if.pll_lock  = !filt;
        resetn = 1'b0;
        exp_rc = 0;
        push(c + 1, bring_snap(0, 0, 0), "reset");
        push(c + 2, bring_snap(0, 0, 0), "reset");
        tick();
        tick();
        r = cyc;
        resetn = 1'b1;
        for (int k = 1; k <= 25; k++) push(r + k, bring_snap(k, d, 0), filt ? "filter" : "nominal");
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (filt && k == 2) seq_if.pll_lock = 1'b1;
            if (filt && k == 7) seq_if.pll_lock = 1'b0;
            if (filt && k == 8) seq_if.pll_lock = 1'b1;
        end
    endtask

    // From RUN: one-cycle lock drop, full re-bring-up.
    task automatic run_loss();
        int unsigned s;
        int          new_rc;
        s = cyc;
        push(s + 1, bring_snap(30, 0, exp_rc), "run_hold");
        push(s + 2, bring_snap(30, 0, exp_rc), "run_hold");
        new_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
        for (int k = 0; k < 20; k++) push(s + 3 + k, bring_snap(k, 0, new_rc), "relock");
        seq_if.pll_lock = 1'b0;
        tick();
        seq_if.pll_lock = 1'b1;
        repeat (21) tick();
        exp_rc = new_rc;
    endtask

    // From RUN: lock held low, two timeouts into FAULT, then retry_req recovers.
    task automatic timeout_fault();
        int unsigned s, r;
        snap_t       e;
        s = cyc;
        push(s + 1, bring_snap(30, 0, exp_rc), "run_hold");
        push(s + 2, bring_snap(30, 0, exp_rc), "run_hold");
        exp_rc = exp_rc + 1;
        r = s + 3;
        for (int k = 0; k <= 75; k++) begin
            e    = '0;
            e.rc = 8'(exp_rc);
            if (k < 4 || (k >= 36 && k < 40)) begin
                e.st = 3'd0;
                e.pr = 1'b1;
            end else if (k < 72) begin
                e.st = 3'd1;
            end else begin
                e.st  = 3'd4;
                e.pr  = 1'b1;
                e.flt = 1'b1;
            end
            push(r + k, e, "timeout");
        end
        seq_if.pll_lock = 1'b0;
        while (cyc < r + 75) begin
            tick();
            seq_if.retry_req = (cyc == r + 14);
        end
        for (int k = 0; k < 20; k++) push(r + 76 + k, bring_snap(k, 0, exp_rc), "fault_exit");
        seq_if.retry_req = 1'b1;
        seq_if.pll_lock  = 1'b1;
        tick();
        seq_if.retry_req = 1'b0;
        repeat (19) tick();
    endtask

    // From RUN: lock drop, then asynchronous reset while domains are half released.
    task automatic mid_release_reset();
        int unsigned s, r;
        int          new_rc;
        s = cyc;
        push(s + 1, bring_snap(30, 0, exp_rc), "run_hold");
        push(s + 2, bring_snap(30, 0, exp_rc), "run_hold");
        new_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
        for (int k = 0; k <= 14; k++) push(s + 3 + k, bring_snap(k, 0, new_rc), "pre_reset");
        seq_if.pll_lock = 1'b0;
        tick();
        seq_if.pll_lock = 1'b1;
        repeat (16) tick();
        push(s + 18, bring_snap(0, 0, 0), "async_reset");
        @(posedge clk);
        #2;
        resetn = 1'b0;
        exp_rc = 0;
        tick();
        push(s + 19, bring_snap(0, 0, 0), "async_reset");
        tick();
        r = cyc;
        resetn = 1'b1;
        for (int k = 1; k <= 19; k++) push(r + k, bring_snap(k, 0, 0), "post_reset");
        repeat (19) tick();
    endtask

    initial begin
        resetn           = 1'b1;
        seq_if.pll_lock  = 1'b0;
        seq_if.retry_req = 1'b0;
        #1;
        reset_bringup(1'b0);
        run_loss();
        reset_bringup(1'b1);
        timeout_fault();
        repeat (260) run_loss();
        mid_release_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmds_clk_rst_seq.md
Name: tmds_clk_rst_seq

Overview:
- Reset and lock sequencer that sits beside the TMDS/pixel PLL wrapper and is clocked from the free-running PLL reference clock.
- Drives the PLL reset pin and filters the asynchronous lock output for stability.
- Releases N downstream domain resets in a fixed order, bit 0 first, for example serialiser, then pixel, then video timing.
- Handles lock loss: retries on lock timeout, counts relock events, and latches a fault after too many failed attempts.

Parameters:
- N_DOMAINS, 2, number of sequenced domain resets (1..8).
- PLL_RST_CYCLES, 16, clk cycles pll_reset is held high per attempt (≥2).
- LOCK_STABLE_CYCLES, 1024, consecutive cycles of synced lock=1 required before release (≥2).
- LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before a retry.
- DOMAIN_GAP_CYCLES, 8, cycles between successive domain releases (≥1).
- MAX_RETRIES, 3, timeout retries allowed before FAULT.

Ports:
- clk, in, 1: free-running PLL reference clock.
- resetn, in, 1: asynchronous active-low reset.
- pll_lock, in, 1: raw PLL lock, asynchronous to clk.
- retry_req, in, 1: single-cycle pulse; leaves FAULT.
- pll_reset, out, 1: active-high reset to the PLL.
- dom_rst_n, out, N_DOMAINS: active-low domain resets, registered in the clk domain.
- ready, out, 1: all domains released and lock good.
- fault, out, 1: retries exhausted.
- relock_count, out, 8: number of lock losses seen in RUN; saturates at 255.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Outputs: pll_reset=1, dom_rst_n=0, ready=0, fault=0, relock_count=0.
  - Internal: retry_cnt=0, state=PLLRST, all counters 0.
- Lock synchronisation: pll_lock passes through a 2-flop synchroniser to give lock_s, a 2-cycle latency. All FSM decisions use lock_s only.
- PLLRST:
  - pll_reset=1 and dom_rst_n all 0.
  - Stay for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with both counters cleared.
- WAIT_LOCK:
  - pll_reset=0.
  - stab_cnt increments while lock_s=1 and clears to 0 on lock_s=0.
  - When lock_s=1 for LOCK_STABLE_CYCLES consecutive cycles, go to RELEASE.
  - tmo_cnt increments every cycle. When it reaches LOCK_TIMEOUT_CYCLES:
    - if retry_cnt<MAX_RETRIES: retry_cnt++ and go to PLLRST;
    - otherwise go to FAULT.
  - If stability is met and timeout hits in the same cycle, stability wins.
  - A lock drop in WAIT_LOCK is not a relock event.
- RELEASE:
  - dom_rst_n[i] goes high i*DOMAIN_GAP_CYCLES cycles after entry; bit 0 rises in the first cycle of RELEASE.
  - Go to RUN DOMAIN_GAP_CYCLES cycles after dom_rst_n[N-1] rises.
  - If lock_s=0: go to PLLRST, and all dom_rst_n drop in the next cycle. relock_count is not incremented.
- RUN:
  - ready=1.
  - If lock_s=0: go to PLLRST, relock_count++ (saturating), retry_cnt=0. ready and dom_rst_n drop in the next cycle.
- FAULT:
  - pll_reset=1, fault=1, dom_rst_n=0.
  - retry_req=1 goes to PLLRST with retry_cnt=0 and fault clearing in the next cycle.
  - retry_req is ignored in every other state.
- Outputs: all outputs are registered; no combinational path from inputs to outputs.
- Counter widths: $clog2(param+1) each.
- Glitch rule: a 1-cycle lock_s low during RELEASE or RUN is treated as a real lock loss.

Decomposition:
- Package tmds_clk_pkg:
  - 3-bit state encoding: PLLRST=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.
  - Width helper constants.
- Sub-module sync_2ff (parameter WIDTH=1, reset value 0) for pll_lock; reusable elsewhere.

Test Plan:
All scenarios use N_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, DOMAIN_GAP_CYCLES=2, MAX_RETRIES=1.
- Nominal bring-up: release resetn, pll_lock=1 from cycle 0.
  - pll_reset high for 4 cycles.
  - 2-cycle sync, then 8 stable cycles.
  - dom_rst_n goes 001 → 011 → 111 at 2-cycle spacing.
  - ready=1 two cycles after 111.
- Stability filter: lock toggles 1 for 5 cycles, 0 for 1, then steady 1 → no release until 8 consecutive lock_s=1 cycles; RELEASE is entered exactly once.
- Run lock loss: in RUN, drop pll_lock for 1 cycle → 3 cycles later ready=0, dom_rst_n=000, pll_reset=1, relock_count=1; re-bring-up succeeds.
- Timeout and fault: pll_lock held 0.
  - First timeout after 32 cycles → PLLRST, retry_cnt=1.
  - Second timeout → FAULT with fault=1 and pll_reset=1.
  - retry_req pulse plus lock=1 → normal bring-up, and fault clears.
- Saturation and async reset:
  - 260 RUN lock losses → relock_count stays 255.
  - resetn pulsed low mid-RELEASE → all outputs immediately return to reset values.
